// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetcher: fills a DEPTH-entry queue from a toggle-handshake ROM
// and hands words to the issue stage over a toggle handshake; redirect flushes and restarts.
module fetch_prefetch #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   memTrigger,
  output logic [ADDR_W-1:0]      memAddr,
  input  logic [DATA_W-1:0]      memData,
  input  logic                   memReady,
  input  logic                   triggerIn,
  output logic                   readyOut,
  output logic [DATA_W-1:0]      dataOut,
  output logic [ADDR_W-1:0]      pcOut,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirectPc,
  output logic [$clog2(DEPTH):0] count
);

  // state  | meaning
  // S_IDLE | no request outstanding; issue when queue has room and no redirect
  // S_WAIT | one request outstanding; waiting for the memReady toggle

  localparam int                PW   = $clog2(DEPTH);
  localparam int                CW   = PW + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic                discard, discard_nxt;
  logic                pending;
  logic                trig_prev, ready_prev;
  logic                trig_edge, mem_edge;
  logic                issue, push, pop;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   q_data [DEPTH];
  logic [ADDR_W-1:0]   q_pc   [DEPTH];

  assign trig_edge = (triggerIn != trig_prev);
  assign mem_edge  = (memReady != ready_prev);

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    issue       = 1'b0;
    push        = 1'b0;
    pop         = pending && (count != '0) && !redirect;
    case (state)
      S_IDLE: begin
        if ((count < FULL) && !redirect) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response that lands together with a redirect is simply dropped.
        if (mem_edge) begin
          state_nxt   = S_IDLE;
          discard_nxt = 1'b0;
          push        = !discard && !redirect;
        end else if (redirect) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Edge detectors track the live inputs so release does not see a phantom toggle.
      trig_prev  <= triggerIn;
      ready_prev <= memReady;
      memTrigger <= 1'b0;
      memAddr    <= RESET_PC;
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      readyOut   <= 1'b0;
      dataOut    <= '0;
      pcOut      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      trig_prev  <= triggerIn;
      ready_prev <= memReady;

      if (issue) begin
        memAddr    <= fetch_pc;
        memTrigger <= ~memTrigger;
      end

      if (redirect) begin
        fetch_pc <= redirectPc;
      end else if (push) begin
        fetch_pc <= fetch_pc + STEP;
      end

      if (pop) begin
        dataOut  <= q_data[rd_ptr];
        pcOut    <= q_pc[rd_ptr];
        readyOut <= ~readyOut;
      end

      if (trig_edge) begin
        pending <= 1'b1;
      end else if (pop) begin
        pending <= 1'b0;
      end

      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_data[wr_ptr] <= memData;
      q_pc[wr_ptr]   <= memAddr;
    end
  end

endmodule
